// File: rtl/traffic_seq_ctrl_pkg.sv
// Shared phase encodings, lamp codes and timer helpers for the traffic sequencer.
// Pure declarations; no latency or flow control.
package traffic_pkg;

    typedef enum logic [2:0] {
        NS_G = 3'd0,
        NS_Y = 3'd1,
        AR1  = 3'd2,
        EW_G = 3'd3,
        EW_Y = 3'd4,
        AR2  = 3'd5,
        WALK = 3'd6
    } phase_t;

    localparam logic [2:0] RED = 3'b100;
    localparam logic [2:0] YEL = 3'b010;
    localparam logic [2:0] GRN = 3'b001;

    localparam int TIMER_W = 4;

    // A zero-length phase is stretched to one cycle, so the reload value saturates at 0.
    function automatic logic [TIMER_W-1:0] phase_len_m1(input logic [TIMER_W-1:0] t);
        return (t == '0) ? '0 : t - 1'b1;
    endfunction

endpackage

// File: rtl/traffic_seq_ctrl_if.sv
// Control/lamp bundle of the traffic sequencer; master drives enable and ped_req.
// Combinational wires only; no latency or backpressure.
interface traffic_seq_ctrl_if;
    import traffic_pkg::*;

    logic               enable;
    logic               ped_req;
    logic [2:0]         ns_light;
    logic [2:0]         ew_light;
    logic               walk;
    logic               ped_ack;
    phase_t             phase;
    logic [TIMER_W-1:0] timer_val;

    modport master (
        output enable, ped_req,
        input  ns_light, ew_light, walk, ped_ack, phase, timer_val
    );

    modport slave (
        input  enable, ped_req,
        output ns_light, ew_light, walk, ped_ack, phase, timer_val
    );

endinterface

// File: rtl/traffic_seq_ctrl_phase_timer.sv
// 4-bit loadable down-counter; load has priority, counting stops at zero.
// Count updates on the clock edge after load/enable; enable=0 holds the count.
module phase_timer #(
    parameter logic [3:0] RST_VAL = 4'd0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    input  logic       load,
    input  logic [3:0] load_val,
    output logic [3:0] count,
    output logic       zero
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= RST_VAL;
        end else if (load) begin
            count <= load_val;
        end else if (enable && (count != 4'd0)) begin
            count <= count - 4'd1;
        end
    end

    assign zero = (count == 4'd0);

endmodule

// File: rtl/traffic_seq_ctrl.sv
// Traffic-light sequencer NS_G->NS_Y->AR1->EW_G->EW_Y->AR2 with optional pedestrian WALK (PED_WALK_EN).
// Moore lamp outputs, zero latency from state; enable=0 freezes everything except request capture.
module traffic_seq_ctrl
    import traffic_pkg::*;
#(
    parameter logic [3:0] T_GREEN  = 4'd10,
    parameter logic [3:0] T_YELLOW = 4'd3,
    parameter logic [3:0] T_ALLRED = 4'd1,
    parameter logic [3:0] T_WALK   = 4'd6
) (
    input  logic               clk,
    input  logic               reset,
    traffic_seq_ctrl_if.slave  bus
);

    localparam logic [3:0] GREEN_M1  = phase_len_m1(T_GREEN);
    localparam logic [3:0] YELLOW_M1 = phase_len_m1(T_YELLOW);
    localparam logic [3:0] ALLRED_M1 = phase_len_m1(T_ALLRED);
    localparam logic [3:0] WALK_M1   = phase_len_m1(T_WALK);

    phase_t     state;
    phase_t     state_nxt;
    logic       adv;
    logic       tmr_load;
    logic [3:0] tmr_load_val;
    logic [3:0] tmr_count;
    logic       tmr_zero;

`ifdef PED_WALK_EN
    logic ped_pending;
    logic walk_entry;

    assign walk_entry = (state_nxt == WALK) && (state != WALK);

    // A request coinciding with the WALK entry re-arms pending for the next cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ped_pending <= 1'b0;
        end else begin
            ped_pending <= bus.ped_req | (ped_pending & ~walk_entry);
        end
    end
`else
    logic unused_ped_req;
    assign unused_ped_req = bus.ped_req;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= AR2;
        end else begin
            state <= state_nxt;
        end
    end

    assign adv = bus.enable && tmr_zero;

    always_comb begin
        state_nxt = state;
        case (state)
            NS_G: if (adv) state_nxt = NS_Y;
            NS_Y: if (adv) state_nxt = AR1;
            AR1:  if (adv) state_nxt = EW_G;
            EW_G: if (adv) state_nxt = EW_Y;
            EW_Y: if (adv) state_nxt = AR2;
`ifdef PED_WALK_EN
            AR2:  if (adv) state_nxt = ped_pending ? WALK : NS_G;
            WALK: if (adv) state_nxt = NS_G;
`else
            AR2:  if (adv) state_nxt = NS_G;
`endif
            default: state_nxt = AR2;
        endcase
    end

    // Every transition differs from the current state, so a change of state is the reload strobe;
    // this also covers recovery from an illegal encoding regardless of enable.
    assign tmr_load = (state_nxt != state);

    always_comb begin
        tmr_load_val = ALLRED_M1;
        case (state_nxt)
            NS_G, EW_G: tmr_load_val = GREEN_M1;
            NS_Y, EW_Y: tmr_load_val = YELLOW_M1;
            WALK:       tmr_load_val = WALK_M1;
            default:    tmr_load_val = ALLRED_M1;
        endcase
    end

    phase_timer #(
        .RST_VAL (ALLRED_M1)
    ) u_phase_timer (
        .clk      (clk),
        .reset    (reset),
        .enable   (bus.enable),
        .load     (tmr_load),
        .load_val (tmr_load_val),
        .count    (tmr_count),
        .zero     (tmr_zero)
    );

    always_comb begin
        bus.ns_light = RED;
        bus.ew_light = RED;
        bus.walk     = 1'b0;
        bus.ped_ack  = 1'b0;
        case (state)
            NS_G: bus.ns_light = GRN;
            NS_Y: bus.ns_light = YEL;
            EW_G: bus.ew_light = GRN;
            EW_Y: bus.ew_light = YEL;
`ifdef PED_WALK_EN
            WALK: begin
                bus.walk    = 1'b1;
                bus.ped_ack = (tmr_count == WALK_M1);
            end
`endif
            default: ;
        endcase
    end

    assign bus.phase     = state;
    assign bus.timer_val = tmr_count;

endmodule
